// File: rtl/bolme_birimi_pkg.sv
// bolme_birimi_pkg: operation codes, FSM states and sign helper for the RV32M divide unit
package bolme_birimi_pkg;
    localparam logic [1:0] BOLME_DIV  = 2'b00;
    localparam logic [1:0] BOLME_DIVU = 2'b01;
    localparam logic [1:0] BOLME_REM  = 2'b10;
    localparam logic [1:0] BOLME_REMU = 2'b11;
    typedef enum logic [1:0] {
        BOLME_BOSTA   = 2'b00,
        BOLME_HESAPLA = 2'b01,
        BOLME_DUZELT  = 2'b10,
        BOLME_BITTI   = 2'b11
    } bolme_durum_t;
    function automatic logic [31:0] kosullu_eksi(input logic [31:0] x, input logic en);
        return en ? -x : x;
    endfunction
endpackage

// File: rtl/bolme_adimi.sv
// bolme_adimi: one combinational restoring-division step (kalan, bolunen, bolen in; shifted kalan, bolunen with new quotient bit out)
module bolme_adimi #(
    parameter int XLEN = 32
) (
    input  logic [XLEN:0]   kalan,
    input  logic [XLEN-1:0] bolunen,
    input  logic [XLEN-1:0] bolen,
    output logic [XLEN:0]   kalan_n,
    output logic [XLEN-1:0] bolunen_n
);
    logic [XLEN+1:0] kaydir, fark;
    logic            pozitif;
    always_comb begin
        kaydir    = {kalan, bolunen[XLEN-1]};
        fark      = kaydir - {2'b00, bolen};
        pozitif   = ~fark[XLEN+1];
        kalan_n   = pozitif ? fark[XLEN:0] : kaydir[XLEN:0];
        bolunen_n = {bolunen[XLEN-2:0], pozitif};
    end
endmodule

// File: rtl/bolme_birimi.sv
// bolme_birimi: multi-cycle RV32M DIV/DIVU/REM/REMU unit; clk_i/rst_i, durdur_i stall, basla_i+kontrol_i+deger1_i/deger2_i start, sonuc_o/gecerli_o result, mesgul_o busy
module bolme_birimi
    import bolme_birimi_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic            clk_i,
    input  logic            rst_i,
    input  logic            durdur_i,
    input  logic            basla_i,
    input  logic [1:0]      kontrol_i,
    input  logic [XLEN-1:0] deger1_i,
    input  logic [XLEN-1:0] deger2_i,
    output logic [XLEN-1:0] sonuc_o,
    output logic            gecerli_o,
    output logic            mesgul_o
);
    bolme_durum_t    durum, durum_n;
    logic [1:0]      kontrol;
    logic [XLEN:0]   kalan, kalan_n;
    logic [XLEN-1:0] bolunen, bolunen_n, bolen;
    logic            bolum_isareti, kalan_isareti;
    logic [4:0]      sayac;
    logic            isaretli, s1, s2, sifir, tasma, ozel;
    logic [XLEN-1:0] ozel_sonuc, bolum, kalan_son;
    bolme_adimi #(.XLEN(XLEN)) u_adim (
        .kalan     (kalan),
        .bolunen   (bolunen),
        .bolen     (bolen),
        .kalan_n   (kalan_n),
        .bolunen_n (bolunen_n)
    );
    always_comb begin
        isaretli   = ~kontrol_i[0];
        s1         = isaretli & deger1_i[XLEN-1];
        s2         = isaretli & deger2_i[XLEN-1];
        sifir      = deger2_i == '0;
        tasma      = isaretli && deger1_i == {1'b1, {(XLEN-1){1'b0}}} && deger2_i == '1;
        ozel       = sifir | tasma;
        ozel_sonuc = sifir ? (kontrol_i[1] ? deger1_i : '1) : (kontrol_i[1] ? '0 : deger1_i);
        bolum      = kosullu_eksi(bolunen, bolum_isareti);
        kalan_son  = kosullu_eksi(kalan[XLEN-1:0], kalan_isareti);
        mesgul_o   = durum != BOLME_BOSTA;
        durum_n    = durum == BOLME_BOSTA   ? (basla_i ? (ozel ? BOLME_BITTI : BOLME_HESAPLA) : BOLME_BOSTA) :
                     durum == BOLME_HESAPLA ? (sayac == 5'd31 ? BOLME_DUZELT : BOLME_HESAPLA) :
                     durum == BOLME_DUZELT  ? BOLME_BITTI : BOLME_BOSTA;
    end
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            durum         <= BOLME_BOSTA;
            sonuc_o       <= '0;
            gecerli_o     <= 1'b0;
            sayac         <= '0;
            kontrol       <= BOLME_DIV;
            kalan         <= '0;
            bolunen       <= '0;
            bolen         <= '0;
            bolum_isareti <= 1'b0;
            kalan_isareti <= 1'b0;
        end else if (!durdur_i) begin
            durum     <= durum_n;
            // the valid pulse trails the BITTI state by one registered cycle
            gecerli_o <= durum == BOLME_BITTI;
            if (durum == BOLME_BOSTA && basla_i) begin
                kontrol       <= kontrol_i;
                bolunen       <= kosullu_eksi(deger1_i, s1);
                bolen         <= kosullu_eksi(deger2_i, s2);
                bolum_isareti <= s1 ^ s2;
                kalan_isareti <= s1;
                kalan         <= '0;
                sayac         <= '0;
                if (ozel) sonuc_o <= ozel_sonuc;
            end
            if (durum == BOLME_HESAPLA) begin
                kalan   <= kalan_n;
                bolunen <= bolunen_n;
                sayac   <= sayac + 5'd1;
            end
            if (durum == BOLME_DUZELT) sonuc_o <= kontrol[1] ? kalan_son : bolum;
        end
    end
endmodule

// File: tb/tb_bolme_birimi.sv
// tb_bolme_birimi: directed self-checking bench for bolme_birimi
module tb_bolme_birimi;
    logic        clk_i = 0, rst_i = 1, durdur_i = 0, basla_i = 0;
    logic [1:0]  kontrol_i = 0;
    logic [31:0] deger1_i = 0, deger2_i = 0;
    logic [31:0] sonuc_o;
    logic        gecerli_o, mesgul_o;
    int          toplam = 0, hata = 0;

    bolme_birimi dut (
        .clk_i     (clk_i),
        .rst_i     (rst_i),
        .durdur_i  (durdur_i),
        .basla_i   (basla_i),
        .kontrol_i (kontrol_i),
        .deger1_i  (deger1_i),
        .deger2_i  (deger2_i),
        .sonuc_o   (sonuc_o),
        .gecerli_o (gecerli_o),
        .mesgul_o  (mesgul_o)
    );

    always #5 clk_i = ~clk_i;

    task automatic kontrol_et(input string etiket, input logic [31:0] gozlenen, input logic [31:0] beklenen);
        toplam++;
        if (gozlenen !== beklenen) begin
            hata++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", etiket, gozlenen, beklenen);
        end
    endtask

    // starts one operation; latency counts the start cycle, so k cycles after edge N means k+1
    task automatic calistir(input string ad, input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                            input logic [31:0] beklenen, input int gecikme, input bit durdur_var);
        int  k;
        bit  mesgul_ok, gecerli_gordu;
        mesgul_ok     = 1;
        gecerli_gordu = 0;
        @(negedge clk_i);
        kontrol_i = op; deger1_i = a; deger2_i = b; basla_i = 1;
        @(posedge clk_i); #1;
        basla_i = 0; deger1_i = $urandom; deger2_i = $urandom; kontrol_i = 2'($urandom);
        for (k = 1; k <= 100; k++) begin
            if (durdur_var && k == 5) basla_i = 1;
            if (durdur_var && k == 6) basla_i = 0;
            if (durdur_var && k == 10) durdur_i = 1;
            if (durdur_var && k == 15) durdur_i = 0;
            @(posedge clk_i); #1;
            if (gecerli_o) begin
                gecerli_gordu = 1;
                break;
            end
            if (!mesgul_o) mesgul_ok = 0;
        end
        kontrol_et({ad, " gecerli"}, 32'(gecerli_gordu), 32'd1);
        kontrol_et({ad, " gecikme"}, k + 1, gecikme);
        kontrol_et({ad, " mesgul"}, 32'(mesgul_ok), 32'd1);
        kontrol_et({ad, " sonuc"}, sonuc_o, beklenen);
        @(posedge clk_i); #1;
        kontrol_et({ad, " darbe"}, 32'(gecerli_o), 32'd0);
        kontrol_et({ad, " tutma"}, sonuc_o, beklenen);
    endtask

    initial begin
        bit gecerli_gordu;
        repeat (2) @(posedge clk_i);
        #1;
        rst_i = 0;
        kontrol_et("reset sonuc", sonuc_o, 32'h0);
        kontrol_et("reset gecerli", 32'(gecerli_o), 32'd0);
        kontrol_et("reset mesgul", 32'(mesgul_o), 32'd0);

        calistir("DIV 8470/70", 2'b00, 32'd8470, 32'd70, 32'd121, 35, 0);
        calistir("DIV -8470/70", 2'b00, 32'hFFFFDEEA, 32'd70, 32'hFFFFFF87, 35, 0);
        calistir("DIV 8470/-70", 2'b00, 32'd8470, 32'hFFFFFFBA, 32'hFFFFFF87, 35, 0);
        calistir("REM -7/2", 2'b10, 32'hFFFFFFF9, 32'd2, 32'hFFFFFFFF, 35, 0);
        calistir("REM 7/-2", 2'b10, 32'd7, 32'hFFFFFFFE, 32'd1, 35, 0);
        calistir("REMU 100/7", 2'b11, 32'd100, 32'd7, 32'd2, 35, 0);
        calistir("DIVU ffffffff/11", 2'b01, 32'hFFFFFFFF, 32'h11, 32'h0F0F0F0F, 35, 0);
        calistir("DIV /0", 2'b00, 32'h79, 32'h0, 32'hFFFFFFFF, 2, 0);
        calistir("DIVU /0", 2'b01, 32'h79, 32'h0, 32'hFFFFFFFF, 2, 0);
        calistir("REM /0", 2'b10, 32'h79, 32'h0, 32'h79, 2, 0);
        calistir("REMU /0", 2'b11, 32'h79, 32'h0, 32'h79, 2, 0);
        calistir("DIV ovf", 2'b00, 32'h80000000, 32'hFFFFFFFF, 32'h80000000, 2, 0);
        calistir("REM ovf", 2'b10, 32'h80000000, 32'hFFFFFFFF, 32'h0, 2, 0);
        calistir("DIVU ovf", 2'b01, 32'h80000000, 32'hFFFFFFFF, 32'h0, 35, 0);
        calistir("REMU ovf", 2'b11, 32'h80000000, 32'hFFFFFFFF, 32'h80000000, 35, 0);
        calistir("DIV durdur", 2'b00, 32'd8470, 32'd70, 32'd121, 40, 1);

        @(negedge clk_i);
        kontrol_i = 2'b00; deger1_i = 32'd8470; deger2_i = 32'd70; basla_i = 1;
        @(posedge clk_i); #1;
        basla_i = 0;
        repeat (10) @(posedge clk_i);
        #1;
        rst_i = 1;
        @(posedge clk_i); #1;
        rst_i = 0;
        kontrol_et("abort sonuc", sonuc_o, 32'h0);
        kontrol_et("abort mesgul", 32'(mesgul_o), 32'd0);
        gecerli_gordu = 0;
        repeat (40) begin
            if (gecerli_o || mesgul_o) gecerli_gordu = 1;
            @(posedge clk_i); #1;
        end
        kontrol_et("abort sessiz", 32'(gecerli_gordu), 32'd0);
        calistir("DIV 51/3", 2'b00, 32'd51, 32'd3, 32'd17, 35, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", toplam, hata);
        $finish;
    end
endmodule

// File: doc/bolme_birimi.md
Name: bolme_birimi

Overview:
Multi-cycle RV32M divide unit, the counterpart to carpma_birimi in the execute stage. It executes DIV, DIVU, REM and REMU using a radix-2 restoring algorithm, one quotient bit per cycle. Operation uses a start/valid handshake so the pipeline controller can stall around it. Divide-by-zero and signed-overflow cases resolve in one cycle with RISC-V-mandated results.

Parameters:
XLEN, 32, operand and result width (the only supported value is 32).

Ports:
clk_i  input  1  clock, rising edge
rst_i  input  1  synchronous, active-high reset
durdur_i  input  1  pipeline stall; freezes all internal state while 1
basla_i  input  1  start request; sampled only in BOSTA
kontrol_i  input  2  operation select: `BOLME_DIV / `BOLME_DIVU / `BOLME_REM / `BOLME_REMU
deger1_i  input  XLEN  dividend (rs1)
deger2_i  input  XLEN  divisor (rs2)
sonuc_o  output  XLEN  result; holds the last value until the next completion
gecerli_o  output  1  one-cycle pulse when sonuc_o is updated
mesgul_o  output  1  high whenever state != BOSTA

Behaviour:
- Reset (rst_i=1 at an edge, synchronous): state=BOSTA, sonuc_o=0, gecerli_o=0, mesgul_o=0, counter=0. Reset during an operation aborts it, and no gecerli_o pulse is produced.
- States: BOSTA, HESAPLA, DUZELT, BITTI.
- BOSTA and basla_i=1 (durdur_i=0) at edge N:
  - Latch kontrol_i.
  - Latch |deger1_i| and |deger2_i|. Absolute value applies only for DIV/REM; the unsigned ops take operands raw.
  - Latch the quotient sign (s1 XOR s2) and the remainder sign (s1).
  - Clear the remainder register. Set sayac=0.
- Special cases are checked at the same edge N; the result is loaded directly and the FSM goes to BITTI:
  - deger2_i=0: DIV/DIVU -> 0xFFFFFFFF; REM/REMU -> deger1_i.
  - DIV/REM with deger1_i=0x80000000 and deger2_i=0xFFFFFFFF: DIV -> 0x80000000; REM -> 0.
- Otherwise the FSM goes to HESAPLA.
- HESAPLA, each edge:
  - Shift {kalan,bolunen} left by 1.
  - Trial-subtract the divisor; if the result is non-negative, keep it and set the quotient LSB to 1.
  - sayac++. The edge with sayac=31 moves to DUZELT (32 iterations).
- DUZELT, one edge:
  - Negate the quotient if the quotient sign is set; negate the remainder if the remainder sign is set (signed ops only).
  - Load sonuc_o with the quotient (DIV/DIVU) or the remainder (REM/REMU). Go to BITTI.
- BITTI: gecerli_o=1 for exactly this cycle (registered). The next edge returns to BOSTA.
- Latency:
  - Normal: start sampled at edge N; gecerli_o high in the cycle after edge N+34.
  - Special case: gecerli_o high in the cycle after edge N+1.
  - Back-to-back: basla_i may be reasserted in the first BOSTA cycle after BITTI.
- basla_i is ignored while mesgul_o=1. Operand inputs are don't-care after capture.
- durdur_i=1: no state, counter, register or output changes, including holding gecerli_o in BITTI. durdur_i=1 in BOSTA blocks the start. rst_i overrides durdur_i.
- Arithmetic: remainder register is XLEN+1 bits for the trial subtract. The remainder result always has the sign of the dividend, and the quotient truncates toward zero.

Decomposition:
- tanimlamalar.vh: add `BOLME_DIV=2'b00, `BOLME_DIVU=2'b01, `BOLME_REM=2'b10, `BOLME_REMU=2'b11, and the state encodings BOLME_BOSTA/HESAPLA/DUZELT/BITTI.
- One natural sub-module: bolme_adimi, a combinational single restoring step that takes {kalan, bolunen, bolen} and returns the next {kalan, bolunen}. Instantiate it once, iterated by the FSM.

Test Plan:
- DIV 8470/70, DIV -8470/70, DIV 8470/-70 -> 121, -121 (0xFFFFFF87), -121; gecerli_o exactly 35 cycles after start, 1 cycle wide, mesgul_o high throughout.
- REM -7/2 -> 0xFFFFFFFF; REM 7/-2 -> 1; REMU 100/7 -> 2; DIVU 0xFFFFFFFF/0x11 -> 0x0F0F0F0F.
- Divide by zero with deger1_i=0x00000079: DIV/DIVU -> 0xFFFFFFFF; REM/REMU -> 0x00000079; gecerli_o 2 cycles after start.
- Overflow 0x80000000 / 0xFFFFFFFF: DIV -> 0x80000000, REM -> 0; DIVU -> 0, REMU -> 0x80000000 (the latter two via the normal 35-cycle path).
- durdur_i held high for 5 cycles mid-HESAPLA -> result unchanged (DIV 8470/70=121), gecerli_o at 40 cycles; basla_i pulsed during busy -> ignored.
- rst_i asserted at iteration 10 -> next cycle sonuc_o=0, mesgul_o=0, no gecerli_o; a following DIV 51/3 -> 17.
